// File: rtl/lut_layer_sequencer_if.sv
//------------------------------------------------------------------------------
// Module  : lut_layer_sequencer_if
// Brief   : Input-vector / layer-result stream handshake bundle for the
//           LogicNets layer sequencer.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface lut_layer_sequencer_if #(
    parameter int IN_WIDTH    = 64,
    parameter int NUM_NEURONS = 16
);
    logic                   in_valid;
    logic                   in_ready;
    logic [IN_WIDTH-1:0]    in_data;
    logic                   out_valid;
    logic                   out_ready;
    logic [NUM_NEURONS-1:0] out_data;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

`default_nettype wire

// File: rtl/lut_layer_sequencer.sv
//------------------------------------------------------------------------------
// Module  : lut_layer_sequencer
// Brief   : Evaluates all neurons of a LogicNets layer one per cycle through a
//           single shared, runtime-programmable 256x1 truth-table lookup.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module lut_layer_sequencer #(
    parameter int IN_WIDTH    = 64,
    parameter int NUM_NEURONS = 16,
    parameter int IDX_W       = $clog2(IN_WIDTH),
    parameter int NID_W       = $clog2(NUM_NEURONS)
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    lut_layer_sequencer_if.slave  bus,
    input  wire logic             cfg_tt_we,
    input  wire logic             cfg_conn_we,
    input  wire logic [NID_W-1:0] cfg_neuron,
    input  wire logic [7:0]       cfg_tt_addr,
    input  wire logic             cfg_tt_bit,
    input  wire logic [2:0]       cfg_conn_slot,
    input  wire logic [IDX_W-1:0] cfg_conn_idx,
    output logic                  cfg_err,
    input  wire logic             cfg_err_clr,
    output logic                  busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EVAL = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam int             c_pad_w = 1 << IDX_W;
    localparam logic [NID_W:0] c_last  = (NID_W+1)'(NUM_NEURONS);

    state_t                 state_q, state_d;
    logic [NID_W:0]         n_cnt_q, n_cnt_d;
    logic [IN_WIDTH-1:0]    vec_q, vec_d;
    logic [NUM_NEURONS-1:0] out_data_q, out_data_d;
    logic                   out_valid_q, out_valid_d;
    logic                   cfg_err_q, cfg_err_d;
    logic [IDX_W-1:0]       conn_q [NUM_NEURONS][8];
    logic [IDX_W-1:0]       conn_d [NUM_NEURONS][8];

    logic                   tt_mem [NUM_NEURONS][256];
    logic                   tt_rd_q;

    logic [c_pad_w-1:0]     vec_pad;
    logic [NID_W-1:0]       rd_nid;
    logic [NID_W-1:0]       wr_nid;
    logic [7:0]             rd_addr;
    logic                   busy_w;
    logic                   tt_wr;
    logic                   conn_wr;

    // Indices beyond IN_WIDTH land in the zero padding and read as 0.
    generate
        if (c_pad_w == IN_WIDTH) begin : g_pad_none
            assign vec_pad = vec_q;
        end else begin : g_pad_zero
            assign vec_pad = {{(c_pad_w-IN_WIDTH){1'b0}}, vec_q};
        end
    endgenerate

    assign busy_w       = (state_q != S_IDLE);
    assign busy         = busy_w;
    assign cfg_err      = cfg_err_q;
    assign bus.in_ready = (state_q == S_IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;

    assign tt_wr   = cfg_tt_we && !busy_w;
    assign conn_wr = cfg_conn_we && !cfg_tt_we && !busy_w;

    // Past the last neuron the read port idles on neuron 0; its result is unused.
    assign rd_nid = (n_cnt_q < c_last) ? n_cnt_q[NID_W-1:0] : '0;
    assign wr_nid = n_cnt_q[NID_W-1:0] - NID_W'(1);

    always_comb begin
        rd_addr = '0;
        for (int s = 0; s < 8; s++) begin
            rd_addr[s] = vec_pad[conn_q[rd_nid][s]];
        end
    end

    always_comb begin
        conn_d = conn_q;
        if (conn_wr) begin
            conn_d[cfg_neuron][cfg_conn_slot] = cfg_conn_idx;
        end
    end

    always_comb begin
        cfg_err_d = cfg_err_q;
        if ((cfg_tt_we || cfg_conn_we) && busy_w) begin
            cfg_err_d = 1'b1;
        end else if (cfg_err_clr) begin
            cfg_err_d = 1'b0;
        end
    end

    always_comb begin
        state_d     = state_q;
        n_cnt_d     = n_cnt_q;
        vec_d       = vec_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    vec_d   = bus.in_data;
                    n_cnt_d = '0;
                    state_d = S_EVAL;
                end
            end
            S_EVAL: begin
                // Count k retires the lookup issued at count k-1.
                if (n_cnt_q != '0) begin
                    out_data_d[wr_nid] = tt_rd_q;
                end
                if (n_cnt_q == c_last) begin
                    state_d = S_DONE;
                end else begin
                    n_cnt_d = n_cnt_q + (NID_W+1)'(1);
                end
            end
            S_DONE: begin
                out_valid_d = 1'b1;
                if (out_valid_q && bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            n_cnt_q     <= '0;
            vec_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            cfg_err_q   <= 1'b0;
            for (int n = 0; n < NUM_NEURONS; n++) begin
                for (int s = 0; s < 8; s++) begin
                    conn_q[n][s] <= '0;
                end
            end
        end else begin
            state_q     <= state_d;
            n_cnt_q     <= n_cnt_d;
            vec_q       <= vec_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            cfg_err_q   <= cfg_err_d;
            conn_q      <= conn_d;
        end
    end

    // Truth tables survive reset, so this storage has no reset branch.
    always_ff @(posedge clk) begin
        if (tt_wr) begin
            tt_mem[cfg_neuron][cfg_tt_addr] <= cfg_tt_bit;
        end
        tt_rd_q <= tt_mem[rd_nid][rd_addr];
    end

endmodule

`default_nettype wire
